rr_arbiter_8: RTL and testbench



---
 rtl/rr_arb_pkg.sv | 20 ++
 rtl/decoder_3_8.sv | 20 ++
 rtl/rr_pick8.sv | 44 ++++
 rtl/rr_arbiter_8.sv | 121 ++++++++++++
 tb/tb_rr_arbiter_8.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared types and constants for the 8-client round-robin arbiter
//
// Contents:
//   N_REQ   : number of requesting clients (matches the 3-bit decoder input)
//   IDX_W   : width of an encoded client index
//   HOLD_W  : width of the grant hold counter
//   state_t : arbiter FSM states
package rr_arb_pkg;

  localparam int N_REQ  = 8;
  localparam int IDX_W  = 3;
  localparam int HOLD_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/decoder_3_8.sv
// rtl/decoder_3_8.sv - 3-to-8 one-hot decoder with enable, fed by the arbiter grant
//
// Ports:
//   e          in  : enable; output is all zero when low
//   in_code    in  : 3-bit encoded index
//   out_onehot out : one-hot decode of in_code when e is high
module decoder_3_8 (
  input  logic       e,
  input  logic [2:0] in_code,
  output logic [7:0] out_onehot
);

  always_comb begin
    out_onehot = 8'h00;
    if (e) begin
      out_onehot[in_code] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational round-robin winner selection for 8 clients
//
// Ports:
//   req [7:0] in  : request levels, bit i is client i
//   ptr [2:0] in  : last served client; search starts at ptr+1
//   any       out : at least one request is pending
//   win [2:0] out : first requesting client at or after ptr+1, wrapping 7 -> 0
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win
);

  logic [IDX_W-1:0]   start;
  logic [2*N_REQ-1:0] req_dbl;
  logic [N_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]   offset;

  // 3-bit addition wraps naturally, so ptr=7 starts the search at client 0.
  assign start = ptr + 3'd1;

  // Doubling the vector lets a plain part-select implement the rotation:
  // req_rot[j] is client (start + j) mod 8.
  assign req_dbl = {req, req};
  assign req_rot = req_dbl[start +: N_REQ];

  // Lowest set bit of the rotated vector is the closest client after ptr.
  // Scanning downward lets the lowest index overwrite higher ones.
  always_comb begin
    offset = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) begin
        offset = IDX_W'(j);
      end
    end
  end

  assign any = |req;
  assign win = start + offset;

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-client round-robin arbiter with hold timeout and encoded grant
//
// Ports:
//   clk            in  : system clock, rising edge
//   rst            in  : synchronous active-high reset
//   req [7:0]      in  : per-client request level
//   done           in  : one-cycle release pulse from the granted client
//   grant_en       out : grant valid (decoder enable)
//   grant_idx[2:0] out : granted client (decoder input); held while grant_en is low
//   busy           out : high while a grant or its trailing gap cycle is in progress
//   timeout        out : one-cycle pulse when a grant was force-released by the hold limit
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_en,
  output logic [IDX_W-1:0] grant_idx,
  output logic             busy,
  output logic             timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                grant_en_d;
  logic [IDX_W-1:0]    grant_idx_d;
  logic                busy_d;
  logic                timeout_d;

  logic                pick_any;
  logic [IDX_W-1:0]    pick_win;

  logic                rel_done;
  logic                rel_drop;
  logic                rel_limit;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .win (pick_win)
  );

  assign rel_done  = done;
  assign rel_drop  = ~req[grant_idx];
  assign rel_limit = (hold_q == HOLD_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd7;
      hold_q    <= '0;
      grant_en  <= 1'b0;
      grant_idx <= '0;
      busy      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      grant_en  <= grant_en_d;
      grant_idx <= grant_idx_d;
      busy      <= busy_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    grant_en_d  = grant_en;
    grant_idx_d = grant_idx;
    busy_d      = busy;
    timeout_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_idx_d = pick_win;
          grant_en_d  = 1'b1;
          busy_d      = 1'b1;
          hold_d      = 8'd1;
          state_d     = GRANT;
        end
      end

      GRANT: begin
        if (rel_done || rel_drop || rel_limit) begin
          grant_en_d = 1'b0;
          ptr_d      = grant_idx;
          state_d    = GAP;
          // Only flag a timeout when the client did not let go on its own.
          timeout_d  = rel_limit && !rel_done && !rel_drop;
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end

      GAP: begin
        // Dead cycle between consecutive grants; requests are not sampled here.
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        grant_en_d = 1'b0;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - self-checking bench for rr_arbiter_8 driving decoder_3_8
module tb_rr_arbiter_8;

  localparam int MAXH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       grant_en;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;
  logic [7:0] dec_out;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 = idle, 1 = granting, 2 = gap
  int mode;
  int m_ptr;
  int m_idx;
  int m_hold;
  bit m_en;
  bit m_busy;
  bit m_to;

  always #5 clk = ~clk;

  rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .grant_en  (grant_en),
    .grant_idx (grant_idx),
    .busy      (busy),
    .timeout   (timeout)
  );

  decoder_3_8 u_dec (
    .e          (grant_en),
    .in_code    (grant_idx),
    .out_onehot (dec_out)
  );

  function automatic int next_winner(int p, logic [7:0] r);
    for (int k = 1; k <= 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_dec();
    logic [7:0] v;
    v = 8'h00;
    if (m_en) v[m_idx] = 1'b1;
    return v;
  endfunction

  function automatic string obs_str();
    return $sformatf("got en=%b idx=%0d busy=%b to=%b dec=%h", grant_en, grant_idx, busy, timeout, dec_out);
  endfunction

  function automatic string exp_str();
    return $sformatf("want en=%b idx=%0d busy=%b to=%b dec=%h", m_en, m_idx, m_busy, m_to, exp_dec());
  endfunction

  task automatic model_step();
    int w;
    if (rst) begin
      mode = 0; m_ptr = 7; m_idx = 0; m_hold = 0;
      m_en = 0; m_busy = 0; m_to = 0;
    end else begin
      case (mode)
        0: begin
          m_to = 0;
          w = next_winner(m_ptr, req);
          if (w >= 0) begin
            m_idx = w; m_en = 1; m_busy = 1; m_hold = 1; mode = 1;
          end
        end
        1: begin
          if (done || !req[m_idx] || m_hold == MAXH) begin
            m_to  = (m_hold == MAXH) && !done && req[m_idx];
            m_en  = 0;
            m_ptr = m_idx;
            mode  = 2;
          end else begin
            m_hold++;
          end
        end
        default: begin
          m_busy = 0; m_to = 0; mode = 0;
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'hA5; done = 1'b1;
    tick();
    tick();
    checks++;
    if (grant_en !== 1'b0 || grant_idx !== 3'd0 || busy !== 1'b0 || timeout !== 1'b0 || dec_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_state %s want all zero", obs_str());
    end
    rst = 1'b0; req = 8'h00; done = 1'b0;
    tick();
    checks++;
    if (grant_en !== 1'b0 || busy !== 1'b0 || dec_out !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle_no_req %s want idle", obs_str());
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h01;
    tick();
    checks++;
    if (grant_en !== 1'b1 || grant_idx !== 3'd0 || busy !== 1'b1 || dec_out !== 8'h01) begin
      failures++;
      $display("FAIL single_grant %s want en=1 idx=0 busy=1 dec=01", obs_str());
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) req = 8'h00;
      checks++;
      if (grant_en !== m_en || grant_idx !== 3'(m_idx) || busy !== m_busy || timeout !== m_to || dec_out !== exp_dec()) begin
        failures++;
        $display("FAIL single_release c=%0d %s %s", c, obs_str(), exp_str());
      end
      tick();
    end
  endtask

  task automatic test_rotation();
    logic [2:0] seq[$];
    int starts[$];
    bit prev_en;
    do_reset();
    req = 8'hFF;
    prev_en = 1'b0;
    for (int c = 0; c < 80 && seq.size() < 9; c++) begin
      done = m_en && (m_hold == 2);
      tick();
      checks++;
      if (grant_en !== m_en || grant_idx !== 3'(m_idx) || busy !== m_busy || timeout !== m_to || dec_out !== exp_dec()) begin
        failures++;
        $display("FAIL rotation_cycle c=%0d %s %s", c, obs_str(), exp_str());
      end
      if (grant_en === 1'b1 && !prev_en) begin
        seq.push_back(grant_idx);
        starts.push_back(c);
      end
      prev_en = (grant_en === 1'b1);
    end
    done = 1'b0;
    checks++;
    if (seq.size() != 9) begin
      failures++;
      $display("FAIL rotation_count got %0d grants want 9", seq.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (seq[i] !== 3'(i % 8)) begin
          failures++;
          $display("FAIL rotation_order i=%0d got %0d want %0d", i, seq[i], i % 8);
        end
      end
      // 2 grant cycles + GAP + IDLE between successive grant starts
      for (int i = 1; i < 9; i++) begin
        checks++;
        if (starts[i] - starts[i-1] != 4) begin
          failures++;
          $display("FAIL rotation_spacing i=%0d got %0d want 4", i, starts[i] - starts[i-1]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [2:0] seq[$];
    bit prev_en;
    do_reset();
    req = 8'h81;
    prev_en = 1'b0;
    for (int c = 0; c < 20 && seq.size() < 3; c++) begin
      done = m_en && (m_hold == 1);
      tick();
      checks++;
      if (grant_en !== m_en || grant_idx !== 3'(m_idx) || busy !== m_busy || timeout !== m_to || dec_out !== exp_dec()) begin
        failures++;
        $display("FAIL wrap_cycle c=%0d %s %s", c, obs_str(), exp_str());
      end
      if (grant_en === 1'b1 && !prev_en) seq.push_back(grant_idx);
      prev_en = (grant_en === 1'b1);
    end
    done = 1'b0;
    checks++;
    if (seq.size() != 3 || seq[0] !== 3'd0 || seq[1] !== 3'd7 || seq[2] !== 3'd0) begin
      failures++;
      $display("FAIL wrap_order got %p want 0,7,0", seq);
    end
  endtask

  task automatic test_timeout();
    int runs[$];
    logic [2:0] seq[$];
    int run_len;
    int n_to;
    bit prev_en;
    do_reset();
    req = 8'h04; done = 1'b0;
    run_len = 0; n_to = 0; prev_en = 1'b0;
    for (int c = 0; c < 45; c++) begin
      tick();
      checks++;
      if (grant_en !== m_en || grant_idx !== 3'(m_idx) || busy !== m_busy || timeout !== m_to || dec_out !== exp_dec()) begin
        failures++;
        $display("FAIL timeout_cycle c=%0d %s %s", c, obs_str(), exp_str());
      end
      if (grant_en === 1'b1) begin
        if (!prev_en) seq.push_back(grant_idx);
        run_len++;
      end else if (prev_en) begin
        runs.push_back(run_len);
        run_len = 0;
        checks++;
        if (timeout !== 1'b1) begin
          failures++;
          $display("FAIL timeout_pulse got to=%b want 1 as grant drops", timeout);
        end
      end
      if (timeout === 1'b1) n_to++;
      prev_en = (grant_en === 1'b1);
    end
    checks++;
    if (runs.size() != 2 || runs[0] != MAXH || runs[1] != MAXH) begin
      failures++;
      $display("FAIL timeout_hold_len got %p want two runs of %0d", runs, MAXH);
    end
    checks++;
    if (n_to != 2 || seq.size() < 2 || seq[0] !== 3'd2 || seq[1] !== 3'd2) begin
      failures++;
      $display("FAIL timeout_regrant got pulses=%0d grants=%p want 2 pulses and idx 2,2", n_to, seq);
    end
  endtask

  task automatic test_drop();
    logic [2:0] seq[$];
    int n_to;
    bit prev_en;
    do_reset();
    req = 8'h60; done = 1'b0;
    n_to = 0; prev_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (m_en && m_idx == 5 && m_hold == 3) req = 8'h40;
      tick();
      checks++;
      if (grant_en !== m_en || grant_idx !== 3'(m_idx) || busy !== m_busy || timeout !== m_to || dec_out !== exp_dec()) begin
        failures++;
        $display("FAIL drop_cycle c=%0d %s %s", c, obs_str(), exp_str());
      end
      if (grant_en === 1'b1 && !prev_en) seq.push_back(grant_idx);
      if (timeout === 1'b1) n_to++;
      prev_en = (grant_en === 1'b1);
    end
    checks++;
    if (seq.size() != 2 || seq[0] !== 3'd5 || seq[1] !== 3'd6 || n_to != 0) begin
      failures++;
      $display("FAIL drop_order got grants=%p timeouts=%0d want 5,6 and 0", seq, n_to);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] seq[$];
    bit did_rst;
    bit prev_en;
    do_reset();
    req = 8'h08; done = 1'b0;
    did_rst = 1'b0; prev_en = 1'b0;
    for (int c = 0; c < 12; c++) begin
      rst = !did_rst && m_en && (m_hold == 3);
      if (rst) did_rst = 1'b1;
      tick();
      checks++;
      if (grant_en !== m_en || grant_idx !== 3'(m_idx) || busy !== m_busy || timeout !== m_to || dec_out !== exp_dec()) begin
        failures++;
        $display("FAIL rstmid_cycle c=%0d %s %s", c, obs_str(), exp_str());
      end
      if (rst) begin
        checks++;
        if (grant_en !== 1'b0 || busy !== 1'b0 || timeout !== 1'b0) begin
          failures++;
          $display("FAIL rstmid_abort %s want en=0 busy=0 to=0", obs_str());
        end
      end
      if (grant_en === 1'b1 && !prev_en) seq.push_back(grant_idx);
      prev_en = (grant_en === 1'b1);
    end
    rst = 1'b0;
    checks++;
    if (seq.size() != 2 || seq[0] !== 3'd3 || seq[1] !== 3'd3) begin
      failures++;
      $display("FAIL rstmid_regrant got %p want 3,3", seq);
    end
  endtask

  task automatic test_random();
    int bad;
    do_reset();
    bad = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if (grant_en !== m_en || grant_idx !== 3'(m_idx) || busy !== m_busy || timeout !== m_to || dec_out !== exp_dec()) begin
        failures++;
        bad++;
        if (bad <= 10) $display("FAIL random_cycle c=%0d req=%h %s %s", c, req, obs_str(), exp_str());
      end
    end
    rst = 1'b0; done = 1'b0; req = 8'h00;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_drop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
